// File: rtl/psram_port_arbiter.sv
// psram_port_arbiter: shares one 32-bit PicoMem-style PSRAM port between
// the CPU (port 0) and the DMA/video master (port 1). One request is latched
// at a time, held steady downstream, and completed with a one-cycle ready
// pulse. The RESP and IDLE states leave mem_valid low for at least two
// cycles between transactions.
module psram_port_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        sys_resetn,

    input  logic        s0_valid,
    input  logic [31:0] s0_addr,
    input  logic [3:0]  s0_wstrb,
    input  logic [31:0] s0_wdata,
    output logic        s0_ready,
    output logic [31:0] s0_rdata,

    input  logic        s1_valid,
    input  logic [31:0] s1_addr,
    input  logic [3:0]  s1_wstrb,
    input  logic [31:0] s1_wdata,
    output logic        s1_ready,
    output logic [31:0] s1_rdata,

    input  logic        mem_init_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Address bits at or above ADDR_W are not forwarded to the PSRAM.
    localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                       : 32'((64'd1 << ADDR_W) - 64'd1);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q;
    state_t      state_d;
    logic        grant_q;
    logic        rr_ptr_q;     // port that wins the next tie in round-robin mode
    logic [3:0]  starve_q;     // consecutive port-0 grants while port 1 waited
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        winner;
    logic        take;
    logic [31:0] sel_addr;
    logic [3:0]  sel_wstrb;
    logic [31:0] sel_wdata;

    // Pick the winning port from the requests seen on the IDLE cycle.
    always_comb begin
        winner = s1_valid;
        if (s0_valid && s1_valid) begin
            if (FIXED_PRIO != 0) begin
                winner = (starve_q >= STARVE_MAX);
            end else begin
                winner = rr_ptr_q;
            end
        end
    end

    assign take      = (state_q == IDLE) && mem_init_ready && (s0_valid || s1_valid);
    assign sel_addr  = (winner ? s1_addr : s0_addr) & ADDR_MASK;
    assign sel_wstrb = winner ? s1_wstrb : s0_wstrb;
    assign sel_wdata = winner ? s1_wdata : s0_wdata;

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        mem_valid = 1'b0;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                s0_ready = ~grant_q;
                s1_ready = grant_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping and request capture on the arbitration cycle.
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            grant_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            starve_q <= 4'd0;
            addr_q   <= 32'd0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
        end else if (take) begin
            grant_q  <= winner;
            rr_ptr_q <= ~winner;
            addr_q   <= sel_addr;
            wstrb_q  <= sel_wstrb;
            wdata_q  <= sel_wdata;
            if (winner) begin
                starve_q <= 4'd0;
            end else if (s1_valid && (starve_q != 4'hF)) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end

    // Read data lands in the granted port's register; writes leave it untouched.
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else if ((state_q == BUSY) && mem_ready && (wstrb_q == 4'd0)) begin
            if (grant_q) begin
                rdata1_q <= mem_rdata;
            end else begin
                rdata0_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
    assign s0_rdata  = rdata0_q;
    assign s1_rdata  = rdata1_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Bench for psram_port_arbiter: a round-robin instance and a fixed-priority
// instance, each with a PSRAM responder model and a completion scoreboard.
module tb_psram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_resetn;
    logic        mem_init_ready;

    // round-robin instance
    logic        s0_valid, s1_valid, s0_ready, s1_ready;
    logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata, s0_rdata, s1_rdata;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        mem_valid, mem_ready, grant_id;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    // fixed-priority instance
    logic        f_s0_valid, f_s1_valid, f_s0_ready, f_s1_ready;
    logic [31:0] f_s0_rdata, f_s1_rdata;
    logic        f_mem_valid, f_mem_ready, f_grant_id;
    logic [31:0] f_mem_addr, f_mem_wdata;
    logic [3:0]  f_mem_wstrb;

    psram_port_arbiter #(.ADDR_W(23), .FIXED_PRIO(0), .STARVE_LIMIT(4)) u_rr (
        .clk(clk), .sys_resetn(sys_resetn),
        .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata),
        .s0_ready(s0_ready), .s0_rdata(s0_rdata),
        .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata),
        .s1_ready(s1_ready), .s1_rdata(s1_rdata),
        .mem_init_ready(mem_init_ready), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .grant_id(grant_id)
    );

    psram_port_arbiter #(.ADDR_W(23), .FIXED_PRIO(1), .STARVE_LIMIT(4)) u_fx (
        .clk(clk), .sys_resetn(sys_resetn),
        .s0_valid(f_s0_valid), .s0_addr(32'h0000_0010), .s0_wstrb(4'd0), .s0_wdata(32'd0),
        .s0_ready(f_s0_ready), .s0_rdata(f_s0_rdata),
        .s1_valid(f_s1_valid), .s1_addr(32'h0000_0020), .s1_wstrb(4'd0), .s1_wdata(32'd0),
        .s1_ready(f_s1_ready), .s1_rdata(f_s1_rdata),
        .mem_init_ready(mem_init_ready), .mem_valid(f_mem_valid), .mem_addr(f_mem_addr),
        .mem_wstrb(f_mem_wstrb), .mem_wdata(f_mem_wdata), .mem_ready(f_mem_ready),
        .mem_rdata(32'h1234_5678), .grant_id(f_grant_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    bit   fsb[$];
    bit   grant_log[$];
    bit   f_grant_log[$];

    int          resp_lat   = 1;
    bit          resp_en    = 1'b1;
    bit          resp_fixed = 1'b0;
    logic [31:0] resp_data  = 32'd0;

    function automatic logic [31:0] model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input bit port, input logic [31:0] rdata);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        sys_resetn = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        f_s0_valid = 1'b0; f_s1_valid = 1'b0;
        tick(); tick();
        sb.delete(); fsb.delete(); grant_log.delete(); f_grant_log.delete();
        sys_resetn = 1'b1;
        tick();
    endtask

    task automatic wait_ready(input bit port, input int max, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if ((port == 1'b0 && s0_ready) || (port == 1'b1 && s1_ready)) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: ready on port %0d got none within %0d cycles", name, port, max);
        end
    endtask

    task automatic wait_mem_valid(input int max, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (mem_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: mem_valid got 0 required 1 within %0d cycles", name, max);
        end
    endtask

    // PSRAM model for the round-robin instance
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = 32'h0BAD_0BAD;
                cnt = 0;
            end else if (mem_valid && resp_en) begin
                if (cnt >= resp_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_fixed ? resp_data : model(mem_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // PSRAM model for the fixed-priority instance (one cycle latency)
    initial begin
        f_mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            f_mem_ready = f_mem_valid && !f_mem_ready;
        end
    end

    // Monitor: gap, stability, grant log and completion scoreboard
    initial begin
        int          low_run;
        logic        prev_v;
        logic [31:0] a_hold, d_hold;
        logic [3:0]  w_hold;
        exp_t        e;
        low_run = 2; prev_v = 1'b0;
        a_hold = '0; d_hold = '0; w_hold = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!sys_resetn) begin
                low_run = 2;
                prev_v  = 1'b0;
            end else begin
                if (mem_valid && !prev_v) begin
                    n_tests++;
                    if (low_run < 2) begin
                        n_fail++;
                        $display("FAIL idle_gap: mem_valid low for %0d cycles required >= 2", low_run);
                    end
                    grant_log.push_back(grant_id);
                    a_hold = mem_addr; d_hold = mem_wdata; w_hold = mem_wstrb;
                end else if (mem_valid) begin
                    n_tests++;
                    if (mem_addr !== a_hold || mem_wdata !== d_hold || mem_wstrb !== w_hold) begin
                        n_fail++;
                        $display("FAIL busy_stable: addr/wstrb/wdata %h/%h/%h required %h/%h/%h",
                                 mem_addr, mem_wstrb, mem_wdata, a_hold, w_hold, d_hold);
                    end
                end
                low_run = mem_valid ? 0 : low_run + 1;
                prev_v  = mem_valid;
                if (s0_ready || s1_ready) begin
                    n_tests++;
                    if (s0_ready && s1_ready) begin
                        n_fail++;
                        $display("FAIL ready_onehot: s0_ready=1 s1_ready=1 required only one");
                    end else if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: ready on port %0d, none expected", s1_ready);
                    end else begin
                        e = sb.pop_front();
                        if (s1_ready !== e.port) begin
                            n_fail++;
                            $display("FAIL sb_port: ready on port %0d required port %0d", s1_ready, e.port);
                        end else if ((e.port ? s1_rdata : s0_rdata) !== e.rdata) begin
                            n_fail++;
                            $display("FAIL sb_rdata: port %0d rdata %h required %h",
                                     e.port, e.port ? s1_rdata : s0_rdata, e.rdata);
                        end
                    end
                end
            end
        end
    end

    // Monitor for the fixed-priority instance
    initial begin
        logic prev_v;
        bit   p;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (f_mem_valid && !prev_v && sys_resetn) f_grant_log.push_back(f_grant_id);
            prev_v = f_mem_valid;
            if (sys_resetn && (f_s0_ready || f_s1_ready)) begin
                n_tests++;
                if (fsb.size() == 0) begin
                    n_fail++;
                    $display("FAIL fx_unexpected: ready on port %0d, none expected", f_s1_ready);
                end else begin
                    p = fsb.pop_front();
                    if (f_s1_ready !== p || f_s0_ready === f_s1_ready) begin
                        n_fail++;
                        $display("FAIL fx_port: ready s0=%0d s1=%0d required port %0d",
                                 f_s0_ready, f_s1_ready, p);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        mem_init_ready = 1'b0;
        sys_resetn = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_addr = '0; s1_addr = '0; s0_wstrb = '0; s1_wstrb = '0; s0_wdata = '0; s1_wdata = '0;
        f_s0_valid = 1'b0; f_s1_valid = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if ({mem_valid, s0_ready, s1_ready, grant_id} !== 4'b0 ||
            s0_rdata !== 32'd0 || s1_rdata !== 32'd0 ||
            mem_addr !== 32'd0 || mem_wstrb !== 4'd0 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0d rdy=%0d%0d gid=%0d rdata=%h/%h addr=%h required all 0",
                     mem_valid, s0_ready, s1_ready, grant_id, s0_rdata, s1_rdata, mem_addr);
        end
        sys_resetn = 1'b1;
        s0_addr = 32'h0000_0010; s0_wstrb = 4'd0; s0_valid = 1'b1;
        push_exp(1'b0, model(32'h0000_0010));
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (mem_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL init_gate: mem_valid %0d required 0 while not initialised", mem_valid);
            end
        end
        mem_init_ready = 1'b1;
        tick();
        n_tests++;
        if (mem_valid !== 1'b1 || grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL init_grant: mem_valid=%0d grant_id=%0d required 1/0", mem_valid, grant_id);
        end
        wait_ready(1'b0, 50, "init_done");
        s0_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_read();
        bit seen;
        apply_reset();
        resp_fixed = 1'b1; resp_data = 32'hDEAD_BEEF; resp_lat = 5;
        s0_addr = 32'h0080_0004; s0_wstrb = 4'd0; s0_valid = 1'b1;
        push_exp(1'b0, 32'hDEAD_BEEF);
        wait_mem_valid(10, "read_issue");
        n_tests++;
        if (mem_addr !== 32'h0000_0004 || mem_wstrb !== 4'd0) begin
            n_fail++;
            $display("FAIL read_addr: mem_addr=%h wstrb=%h required 00000004/0", mem_addr, mem_wstrb);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_ready) begin seen = 1'b1; break; end
            n_tests++;
            if (s0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL read_early: s0_ready %0d required 0 before mem_ready", s0_ready);
            end
            tick();
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL read_mem_ready: no mem_ready within 20 cycles");
        end
        tick();
        n_tests++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0 || s0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_resp: s0_ready=%0d s1_ready=%0d rdata=%h required 1/0/deadbeef",
                     s0_ready, s1_ready, s0_rdata);
        end
        s0_valid = 1'b0;
        resp_fixed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (s0_ready !== 1'b0 || s0_rdata !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL read_hold: s0_ready=%0d rdata=%h required 0/deadbeef", s0_ready, s0_rdata);
            end
        end
    endtask

    task automatic test_round_robin();
        int  nrdy;
        bit  want[4];
        apply_reset();
        resp_lat = 1;
        want = '{1'b0, 1'b1, 1'b0, 1'b1};
        s0_addr = 32'h0000_0100; s0_wstrb = 4'd0;
        s1_addr = 32'h0000_0200; s1_wstrb = 4'd0;
        for (int i = 0; i < 4; i++)
            push_exp(want[i], want[i] ? model(32'h0000_0200) : model(32'h0000_0100));
        s0_valid = 1'b1; s1_valid = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 100 && nrdy < 4; i++) begin
            tick();
            if (s0_ready || s1_ready) nrdy++;
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (nrdy != 4 || grant_log.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count: %0d readys %0d grants required 4/4", nrdy, grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (grant_log[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL rr_order: grant %0d port %0d required %0d", i, grant_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_fixed_prio();
        int nrdy;
        bit want[10];
        apply_reset();
        want = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) fsb.push_back(want[i]);
        f_s0_valid = 1'b1; f_s1_valid = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 200 && nrdy < 10; i++) begin
            tick();
            if (f_s0_ready || f_s1_ready) nrdy++;
        end
        f_s0_valid = 1'b0; f_s1_valid = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (nrdy != 10 || f_grant_log.size() != 10) begin
            n_fail++;
            $display("FAIL fx_count: %0d readys %0d grants required 10/10", nrdy, f_grant_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_tests++;
                if (f_grant_log[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL fx_order: grant %0d port %0d required %0d", i, f_grant_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_write_priority();
        logic [31:0] s0_before;
        apply_reset();
        resp_lat = 2;
        s0_addr = 32'h0000_0040; s0_wstrb = 4'd0; s0_valid = 1'b1;
        push_exp(1'b0, model(32'h0000_0040));
        wait_ready(1'b0, 30, "wr_prefill");
        s0_valid = 1'b0;
        s0_before = model(32'h0000_0040);
        tick();
        resp_lat = 4;
        s1_addr = 32'h0000_0300; s1_wstrb = 4'b0100; s1_wdata = 32'h00AB_0000; s1_valid = 1'b1;
        push_exp(1'b1, s1_rdata);
        wait_mem_valid(10, "wr_issue");
        n_tests++;
        if (grant_id !== 1'b1 || mem_wstrb !== 4'b0100 || mem_wdata !== 32'h00AB_0000) begin
            n_fail++;
            $display("FAIL wr_issue_vals: gid=%0d wstrb=%b wdata=%h required 1/0100/00ab0000",
                     grant_id, mem_wstrb, mem_wdata);
        end
        s0_valid = 1'b1;
        push_exp(1'b0, model(32'h0000_0040));
        wait_ready(1'b1, 30, "wr_done");
        s1_valid = 1'b0;
        n_tests++;
        if (s0_rdata !== s0_before || s0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_s0_untouched: s0_rdata=%h s0_ready=%0d required %h/0",
                     s0_rdata, s0_ready, s0_before);
        end
        wait_ready(1'b0, 30, "wr_then_s0");
        s0_valid = 1'b0;
        tick();
        n_tests++;
        if (grant_log.size() != 3 || grant_log[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_order: %0d grants, last port %0d required 3 grants ending at 0",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[grant_log.size()-1] : 1'b1);
        end
    endtask

    task automatic test_reset_busy();
        apply_reset();
        resp_en = 1'b0;
        s0_addr = 32'h0000_0500; s0_wstrb = 4'd0; s0_valid = 1'b1;
        wait_mem_valid(10, "rb_issue");
        tick(); tick();
        sys_resetn = 1'b0;
        s0_valid = 1'b0;
        tick();
        n_tests++;
        if (mem_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_drop: mem_valid=%0d rdy=%0d%0d required 0/00", mem_valid, s0_ready, s1_ready);
        end
        tick();
        sys_resetn = 1'b1;
        resp_en = 1'b1;
        resp_lat = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (s0_ready !== 1'b0 || mem_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rb_quiet: s0_ready=%0d mem_valid=%0d required 0/0", s0_ready, mem_valid);
            end
        end
        s1_addr = 32'h0000_0600; s1_wstrb = 4'd0; s1_valid = 1'b1;
        push_exp(1'b1, model(32'h0000_0600));
        wait_mem_valid(10, "rb_regrant");
        n_tests++;
        if (grant_id !== 1'b1 || mem_addr !== 32'h0000_0600) begin
            n_fail++;
            $display("FAIL rb_regrant_vals: gid=%0d addr=%h required 1/00000600", grant_id, mem_addr);
        end
        wait_ready(1'b1, 30, "rb_done");
        s1_valid = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_fixed_prio();
        test_write_priority();
        test_reset_busy();
        n_tests++;
        if (sb.size() != 0 || fsb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d/%0d completions outstanding required 0", sb.size(), fsb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/psram_port_arbiter.md
Name: psram_port_arbiter

Overview:
- Shares the single 32-bit PicoMem-style PSRAM port (dual-chip PSRAM controller wrapper) between two requesters: CPU (port 0) and DMA/video (port 1).
- Latches one request at a time, drives it downstream, and returns read data with a one-cycle registered ready pulse.
- Enforces an idle gap after every completion so the downstream controller never sees a stale valid.
- Sits between the interconnect and the PSRAM wrapper in the top level.

Parameters:
- ADDR_W, 23: forwarded address width; upper bits of requester addresses are zeroed.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 wins ties, subject to STARVE_LIMIT.
- STARVE_LIMIT, 4: in fixed mode, number of consecutive port-0 grants after which a pending port-1 request wins; must be 1–15.

Ports:
- clk  in  1  system clock.
- sys_resetn  in  1  synchronous active-low reset.
- s0_valid, s1_valid  in  1 each  request; held high until the matching ready.
- s0_addr, s1_addr  in  32 each  byte address.
- s0_wstrb, s1_wstrb  in  4 each  byte strobes; 0 = read.
- s0_wdata, s1_wdata  in  32 each  write data.
- s0_ready, s1_ready  out  1 each  one-cycle completion pulse.
- s0_rdata, s1_rdata  out  32 each  read data; valid while ready is high and held until the next completion on that port.
- mem_init_ready  in  1  downstream initialisation done.
- mem_valid  out  1  downstream request.
- mem_addr  out  32  downstream address.
- mem_wstrb  out  4  downstream byte strobes.
- mem_wdata  out  32  downstream write data.
- mem_ready  in  1  downstream one-cycle completion pulse.
- mem_rdata  in  32  downstream read data; valid only while mem_ready is high.
- grant_id  out  1  port currently owning the downstream port (debug).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on sys_resetn.
- Reset values:
  - all outputs 0;
  - state = IDLE;
  - round-robin pointer = port 0;
  - starvation counter = 0.
- Reset mid-transaction drops mem_valid next edge; no ready is issued.
- IDLE:
  - no grant while mem_init_ready = 0;
  - otherwise, if any valid is high, pick a winner, capture its addr (bits ≥ ADDR_W forced to 0), wstrb and wdata into registers, set mem_valid = 1 and grant_id, then go to BUSY.
- Arbitration (combinational on the IDLE cycle):
  - Round-robin: when both ports request, the port not served last wins; the pointer updates on each grant.
  - Fixed: port 0 wins unless port 1 is pending and the counter has reached STARVE_LIMIT.
  - Counter: increments on each port-0 grant while port 1 is pending; clears on any port-1 grant; saturates.
- BUSY:
  - mem_* held constant from the captured registers; requester inputs are ignored.
  - On mem_ready: capture mem_rdata into the granted port's rdata register, clear mem_valid on the same edge, go to RESP.
- RESP (exactly one cycle): sN_ready = 1 for the granted port only; the next state is IDLE.
- Timing:
  - Minimum gap between two downstream mem_valid assertions: 2 cycles.
  - Minimum latency from a granted sN_valid to sN_ready: downstream latency + 2 cycles.
- Writes: rdata register not updated.
- Requester drops valid while not granted: the request is withdrawn with no side effects.
- Requester drops valid while granted: the transaction still completes and ready still pulses.
- mem_ready outside BUSY: ignored.

Test Plan:
- Reset then mem_init_ready = 0 with s0_valid = 1 → mem_valid stays 0; raise mem_init_ready → mem_valid next cycle, grant_id = 0.
- s0 read of addr 0x0080_0004 and mem_ready with rdata 0xDEADBEEF 5 cycles later:
  - mem_addr = 0x0000_0004;
  - s0_ready pulses 1 cycle after mem_ready;
  - s0_rdata = 0xDEADBEEF and held afterwards.
- Round-robin, both valid continuously → grants alternate 0,1,0,1; mem_valid low for ≥2 cycles between transactions.
- FIXED_PRIO = 1, STARVE_LIMIT = 4, both valid continuously → grant sequence 0,0,0,0,1,0,0,0,0,1.
- s1 write wstrb = 4'b0100, wdata 0x00AB0000, with s0_valid rising during BUSY:
  - mem_wstrb = 4'b0100 and stable;
  - s0 served only after s1_ready;
  - s0_rdata unchanged by the write.
- Assert sys_resetn = 0 during BUSY → mem_valid = 0 next edge, no ready; the next request after reset is granted normally.
